// File: rtl/exc_ctrl.sv
// Exception sequencer: turns syscall/eret/interrupt events into a CP0 request,
// a stall/flush window and a fetch redirect. Interrupt path gated by EXC_CTRL_IRQ_EN.
module exc_ctrl #(
    parameter int unsigned NIRQ         = 6,
    parameter logic [29:0] VEC_ADDR     = 30'h0000_0060,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [2:0]      id_cp0op,
    input  logic [29:0]     id_pc,
    input  logic [NIRQ-1:0] irq,
    input  logic            status_ie,
    input  logic            status_exl,
    input  logic [31:0]     epc,
    output logic [2:0]      cp0_req_op,
    output logic [29:0]     exc_pc,
    output logic [4:0]      exc_code,
    output logic            stall,
    output logic            flush,
    output logic            redirect,
    output logic [29:0]     redirect_pc
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [2:0] OP_NONE    = 3'b000;
    localparam logic [2:0] OP_SYSCALL = 3'b011;
    localparam logic [2:0] OP_ERET    = 3'b100;
    localparam logic [4:0] CODE_SYS   = 5'd8;
    localparam logic [4:0] CODE_INT   = 5'd0;

    typedef enum logic [1:0] {IDLE, TRAP, DRAIN, REDIR} state_e;

    state_e           state_q, state_d;
    logic [2:0]       cp0_req_op_q, cp0_req_op_d;
    logic [29:0]      exc_pc_q, exc_pc_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic             stall_q, stall_d;
    logic             flush_q, flush_d;
    logic             redirect_q, redirect_d;
    logic [29:0]      redirect_pc_q, redirect_pc_d;
    logic [29:0]      target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_pend_c;
    logic             syscall_c;
    logic             eret_c;

    // EPC is word aligned; the byte offset bits carry no information here.
    logic unused_epc;
    assign unused_epc = ^epc[1:0];

`ifdef EXC_CTRL_IRQ_EN
    logic [NIRQ-1:0] irq_s1_q, irq_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_s1_q <= '0;
            irq_s2_q <= '0;
        end else begin
            irq_s1_q <= irq;
            irq_s2_q <= irq_s1_q;
        end
    end

    assign irq_pend_c = (|irq_s2_q) & status_ie & ~status_exl;
`else
    logic unused_irq;
    assign unused_irq = ^{irq, status_ie};
    assign irq_pend_c = 1'b0;
`endif

    assign syscall_c = id_valid && (id_cp0op == OP_SYSCALL);
    assign eret_c    = id_valid && (id_cp0op == OP_ERET) && status_exl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cp0_req_op_q  <= OP_NONE;
            exc_pc_q      <= '0;
            exc_code_q    <= '0;
            stall_q       <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            target_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cp0_req_op_q  <= cp0_req_op_d;
            exc_pc_q      <= exc_pc_d;
            exc_code_q    <= exc_code_d;
            stall_q       <= stall_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            target_q      <= target_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next state and registered-output updates; ID and irq are only looked at in IDLE.
    always_comb begin
        state_d       = state_q;
        cp0_req_op_d  = cp0_req_op_q;
        exc_pc_d      = exc_pc_q;
        exc_code_d    = exc_code_q;
        stall_d       = stall_q;
        flush_d       = flush_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;
        target_d      = target_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (syscall_c) begin
                    state_d      = TRAP;
                    exc_pc_d     = id_pc;
                    exc_code_d   = CODE_SYS;
                    target_d     = VEC_ADDR;
                    cp0_req_op_d = OP_SYSCALL;
                    stall_d      = 1'b1;
                end else if (eret_c) begin
                    state_d      = TRAP;
                    target_d     = epc[31:2];
                    cp0_req_op_d = OP_ERET;
                    stall_d      = 1'b1;
                end else if (irq_pend_c) begin
                    state_d      = TRAP;
                    exc_pc_d     = id_pc;
                    exc_code_d   = CODE_INT;
                    target_d     = VEC_ADDR;
                    cp0_req_op_d = OP_SYSCALL;
                    stall_d      = 1'b1;
                end
            end
            TRAP: begin
                state_d      = DRAIN;
                cp0_req_op_d = OP_NONE;
                flush_d      = 1'b1;
                cnt_d        = CNT_INIT;
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d       = REDIR;
                    flush_d       = 1'b0;
                    redirect_d    = 1'b1;
                    redirect_pc_d = target_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REDIR: begin
                state_d    = IDLE;
                redirect_d = 1'b0;
                stall_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cp0_req_op  = cp0_req_op_q;
    assign exc_pc      = exc_pc_q;
    assign exc_code    = exc_code_q;
    assign stall       = stall_q;
    assign flush       = flush_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule
